pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage RV32I pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-stage enable, flush and bubble controls from load-use hazards, taken branches/jumps and a data-memory wait-state handshake.
- Drives the EX-stage forwarding selects, detects memory timeouts, and keeps saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16: max consecutive wait cycles on a data-memory access before error; legal range 1..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_rs1, ex_rs2  in  5 each  source registers held in ID/EX.
- ex_rd  in  5  destination in ID/EX.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump (redirect).
- mem_rd  in  5  destination in EX/MEM.
- mem_reg_write  in  1  write-enable in EX/MEM.
- mem_dmem_req  in  1  EX/MEM instruction is accessing data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- wb_rd  in  5  destination in MEM/WB.
- wb_reg_write  in  1  write-enable in MEM/WB.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  stage register load enables.
- if_id_flush, id_ex_flush  out  1 each  synchronous clear of the register (bubble insert).
- mem_wb_bubble  out  1  MEM/WB captures a NOP (reg_write=0).
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 00 = regfile, 01 = WB, 10 = MEM.
- mem_err  out  1  sticky timeout error.
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Behaviour:
- State machine: states RUN, MEM_WAIT, ERR. Registered state is wait_cnt[7:0]; all control outputs are combinational from state and inputs.

Reset (rst_n low, asynchronous):
- State RUN; wait_cnt = 0; mem_err = 0; both counters 0.
- While rst_n is low, force all enables 0, flushes 0, bubble 0, fwd 00.

Mem stall (highest priority):
- Condition: (RUN or MEM_WAIT) with mem_dmem_req=1 and dmem_ready=0.
- Outputs: all four enables 0, mem_wb_bubble=1, flushes 0.
- Next state MEM_WAIT; wait_cnt increments.
- When wait_cnt reaches MEM_TIMEOUT: next state ERR.

MEM_WAIT exit:
- With dmem_ready=1 (or mem_dmem_req dropped): no stall that cycle; MEM/WB captures the data normally.
- Next state RUN; wait_cnt = 0.
- dmem_ready=1 in RUN on the first cycle gives zero stall.

Branch flush (second priority):
- Condition: ex_branch_taken=1 and no mem stall.
- Outputs: pc_en=1, if_id_flush=1, id_ex_flush=1, all other enables 1.
- Overrides load-use, because the dependent younger instruction is killed.
- A branch held during a mem stall is frozen in EX and flushes on the release cycle.

Load-use (third priority):
- Condition: ex_mem_read=1, ex_rd≠0, and (id_uses_rs1 with id_rs1==ex_rd, or id_uses_rs2 with id_rs2==ex_rd).
- Outputs: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. Lasts exactly 1 cycle.

Normal operation:
- All enables 1, flushes 0, bubble 0.

ERR state:
- All enables 0, mem_err=1, mem_wb_bubble=1.
- Left only by reset.

Forwarding (all states):
- fwd_a_sel = 10 if mem_reg_write, mem_rd≠0 and mem_rd==ex_rs1.
- Else 01 if wb_reg_write, wb_rd≠0 and wb_rd==ex_rs1.
- Else 00.
- fwd_b_sel follows the same rule using ex_rs2. MEM takes priority over WB.

Counters:
- stall_cnt increments on every non-reset cycle with pc_en=0, including ERR.
- flush_cnt increments on every cycle with if_id_flush=1.
- Both saturate at all-ones (no wrap).

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1; the next cycle is normal.
2. Branch plus load-use in the same cycle: ex_branch_taken=1 and the hazard as in 1 -> pc_en=1, if_id_flush=1, id_ex_flush=1; flush_cnt=1; stall_cnt unchanged.
3. Mem wait: mem_dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 cycles of all enables 0 with mem_wb_bubble=1; release on cycle 4; state back to RUN; stall_cnt=3.
4. Timeout: MEM_TIMEOUT=4 and dmem_ready held at 0 -> mem_err=1 after 4 wait cycles, enables stuck at 0; rst_n pulse low returns to RUN with mem_err=0.
5. Forwarding: ex_rs1=7, mem_rd=7, mem_reg_write=1, wb_rd=7, wb_reg_write=1 -> fwd_a_sel=10. With mem_rd=0 -> 01. With ex_rs2=0 and wb_rd=0 -> fwd_b_sel=00.
6. Async reset mid-stall: rst_n low between clock edges during MEM_WAIT -> outputs drop immediately to 0, counters 0; after release the block is in RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle between the RV32I pipeline datapath and pipe_hazard_ctrl.
// Ports:
//   Status from the datapath: ID/EX/MEM/WB register indices, write-enables, load flag,
//   branch redirect and the data-memory handshake.
//   Controls to the datapath: stage enables, flushes, MEM/WB bubble, forwarding selects,
//   the timeout error and the performance counters.
// master: the datapath side. slave: the controller side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  // datapath status
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic             mem_dmem_req;
  logic             dmem_ready;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  // controller outputs
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_mem_read, ex_branch_taken, mem_rd, mem_reg_write, mem_dmem_req,
           dmem_ready, wb_rd, wb_reg_write,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           mem_wb_bubble, fwd_a_sel, fwd_b_sel, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_mem_read, ex_branch_taken, mem_rd, mem_reg_write, mem_dmem_req,
           dmem_ready, wb_rd, wb_reg_write,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           mem_wb_bubble, fwd_a_sel, fwd_b_sel, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage RV32I pipeline registers.
// Priority: memory wait-state stall > taken-branch flush > load-use stall > run.
// Control outputs are combinational from the registered state and the current inputs;
// mem_err and the counters are registered.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; forces every control output low while asserted
//   bus    pipe_hazard_ctrl_if.slave (status in, stage controls/counters out)
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic       mem_stall_c, load_use_c;
  logic       pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c;
  logic       if_id_flush_c, id_ex_flush_c, bubble_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // EX operand source: MEM result beats the older WB result; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (m_we && (m_rd != 5'd0) && (m_rd == rs)) return 2'b10;
    if (w_we && (w_rd != 5'd0) && (w_rd == rs)) return 2'b01;
    return 2'b00;
  endfunction

  // Hazard detection, next-state and control outputs.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pc_en_c       = 1'b0;
    if_id_en_c    = 1'b0;
    id_ex_en_c    = 1'b0;
    ex_mem_en_c   = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    bubble_c      = 1'b0;
    fwd_a_c       = 2'b00;
    fwd_b_c       = 2'b00;

    mem_stall_c = (state_q != ERR) && bus.mem_dmem_req && !bus.dmem_ready;
    load_use_c  = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                  ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_stall_c) begin
          wait_d  = wait_q + 8'd1;
          state_d = ((wait_q + 8'd1) == TIMEOUT) ? ERR : MEM_WAIT;
        end else begin
          wait_d  = 8'd0;
          state_d = RUN;
        end
      end
      default: state_d = ERR;
    endcase

    if (rst_n) begin
      fwd_a_c = fwd_sel(bus.ex_rs1, bus.mem_rd, bus.mem_reg_write, bus.wb_rd, bus.wb_reg_write);
      fwd_b_c = fwd_sel(bus.ex_rs2, bus.mem_rd, bus.mem_reg_write, bus.wb_rd, bus.wb_reg_write);
      if (state_q == ERR || mem_stall_c) begin
        // Whole pipe frozen; MEM/WB takes a NOP so the waiting access is not retired twice.
        bubble_c = 1'b1;
      end else if (bus.ex_branch_taken) begin
        // Redirect kills both younger instructions, which also resolves any load-use.
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        id_ex_en_c    = 1'b1;
        ex_mem_en_c   = 1'b1;
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
      end else if (load_use_c) begin
        // Hold PC and IF/ID, send a bubble into EX; the load moves on to MEM.
        id_ex_en_c    = 1'b1;
        ex_mem_en_c   = 1'b1;
        id_ex_flush_c = 1'b1;
      end else begin
        pc_en_c     = 1'b1;
        if_id_en_c  = 1'b1;
        id_ex_en_c  = 1'b1;
        ex_mem_en_c = 1'b1;
      end
    end
  end

  // State and wait-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Saturating stall/flush performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en_c && (stall_q != '1))      stall_q <= stall_q + CNT_W'(1);
      if (if_id_flush_c && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.pc_en         = pc_en_c;
  assign bus.if_id_en      = if_id_en_c;
  assign bus.id_ex_en      = id_ex_en_c;
  assign bus.ex_mem_en     = ex_mem_en_c;
  assign bus.if_id_flush   = if_id_flush_c;
  assign bus.id_ex_flush   = id_ex_flush_c;
  assign bus.mem_wb_bubble = bubble_c;
  assign bus.fwd_a_sel     = fwd_a_c;
  assign bus.fwd_b_sel     = fwd_b_c;
  assign bus.mem_err       = (state_q == ERR);
  assign bus.stall_cnt     = stall_q;
  assign bus.flush_cnt     = flush_q;

endmodule
